// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage; ALU ops pass to writeback in 1 cycle, loads/stores run a DMEM handshake with a 15-cycle timeout.
// Ports: clk/reset_n (async active-low); ex_* instruction from EX; mem_stall holds upstream;
// dm_* DMEM request/response; wb_* registered writeback outputs; err_timeout sticky DMEM timeout.
module memory_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_o,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_insn,
  input  logic        ex_dmwe,
  input  logic        ex_rwd,
  input  logic        ex_rwe,
  input  logic        ex_rdst,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_rwe,
  output logic        wb_rdst,
  output logic        wb_rwd,
  output logic [31:0] wb_o,
  output logic [31:0] wb_d,
  output logic [31:0] wb_insn,
  output logic        err_timeout
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;
  logic        r_state, r_pend, r_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_o, r_b, r_insn;
  logic        r_dmwe, r_rwd, r_rwe, r_rdst;
  logic        w_wait, w_mem, w_take;
  assign w_wait = r_state == S_WAIT;
  assign w_mem  = ex_dmwe || ex_rwd;
  // EX is only looked at in IDLE or on the ack edge (back-to-back accept).
  assign w_take = ex_valid && (!w_wait || dm_ack);
  assign mem_stall   = w_wait && !dm_ack;
  assign dm_req      = w_wait;
  assign dm_we       = w_wait && r_dmwe;
  assign dm_addr     = {r_o[31:2], 2'b00};
  assign dm_wdata    = r_b;
  assign err_timeout = r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 4'd0;
      r_o      <= 32'd0;
      r_b      <= 32'd0;
      r_insn   <= 32'd0;
      r_dmwe   <= 1'b0;
      r_rwd    <= 1'b0;
      r_rwe    <= 1'b0;
      r_rdst   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rwe   <= 1'b0;
      wb_rdst  <= 1'b0;
      wb_rwd   <= 1'b0;
      wb_o     <= 32'd0;
      wb_d     <= 32'd0;
      wb_insn  <= 32'd0;
    end else begin
      if (w_wait && (dm_ack || r_cnt == 4'd14)) begin
        // Ack wins over a timeout landing on the same edge.
        wb_valid <= 1'b1;
        wb_rwe   <= dm_ack && r_rwe;
        wb_rdst  <= r_rdst;
        wb_rwd   <= r_rwd;
        wb_o     <= r_o;
        wb_insn  <= r_insn;
        wb_d     <= !dm_ack ? 32'hDEADBEEF : r_rwd ? dm_rdata : 32'd0;
        r_err    <= r_err || !dm_ack;
        r_state  <= S_IDLE;
      end else if (r_pend) begin
        // ALU op taken on an ack edge drains one cycle later.
        wb_valid <= 1'b1;
        wb_rwe   <= r_rwe;
        wb_rdst  <= r_rdst;
        wb_rwd   <= r_rwd;
        wb_o     <= r_o;
        wb_insn  <= r_insn;
        wb_d     <= 32'd0;
      end else if (!w_wait && ex_valid && !w_mem) begin
        wb_valid <= 1'b1;
        wb_rwe   <= ex_rwe;
        wb_rdst  <= ex_rdst;
        wb_rwd   <= ex_rwd;
        wb_o     <= ex_o;
        wb_insn  <= ex_insn;
        wb_d     <= 32'd0;
      end else begin
        wb_valid <= 1'b0;
        wb_rwe   <= 1'b0;
      end
      if (w_wait && !dm_ack)
        r_cnt <= r_cnt + 4'd1;
      r_pend <= w_take && !w_mem && (w_wait || r_pend);
      if (w_take) begin
        r_o    <= ex_o;
        r_b    <= ex_b;
        r_insn <= ex_insn;
        r_dmwe <= ex_dmwe;
        r_rwd  <= ex_rwd;
        r_rwe  <= ex_rwe;
        r_rdst <= ex_rdst;
        if (w_mem) begin
          r_state <= S_WAIT;
          r_cnt   <= 4'd0;
        end
      end
    end
  end
endmodule
